i2c_target_regfile: RTL and testbench

I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

---
 rtl/i2c_target_regfile.sv | 226 ++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// ---------------------------------------------------------------------------
// i2c_target_regfile
// I2C target (slave) that exposes a small register file to an I2C controller.
// A controller write sets the register pointer from the first data byte and
// stores any following bytes at successive pointer values. A controller read
// returns bytes starting at the current pointer. The pointer wraps modulo
// NUM_REGS and is kept across STOP.
//
// Ports
//   clk          : system clock, all logic on the rising edge
//   rst          : synchronous active-high reset
//   scl_pad_i    : asynchronous SCL line level
//   sda_pad_i    : asynchronous SDA line level
//   sda_padoen_o : SDA output enable, active-low (0 pulls SDA low)
//   wr_stb_o     : one-cycle pulse when a byte is stored from the bus
//   wr_addr_o    : register index of that store
//   wr_data_o    : byte stored
//   loc_addr_i   : local read index
//   loc_rdata_o  : combinational contents of regs[loc_addr_i]
//   busy_o       : high from a detected START until a detected STOP
// ---------------------------------------------------------------------------
module i2c_target_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         FILT_CYCLES = 3,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_pad_i,
  input  logic          sda_pad_i,
  output logic          sda_padoen_o,
  output logic          wr_stb_o,
  output logic [PW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o,
  input  logic [PW-1:0] loc_addr_i,
  output logic [7:0]    loc_rdata_o,
  output logic          busy_o
);

  localparam int            CW       = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CW-1:0] FILT_MAX = CW'(FILT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_e;

  // Bit 0 of these pairs carries SCL, bit 1 carries SDA.
  logic [1:0]    meta_q, sync_q, filt_q, filt_d, prev_q;
  logic [CW-1:0] filtCnt_q [2];
  logic [CW-1:0] filtCnt_d [2];

  logic          sclF, sdaF, sclRise, sclFall, startDet, stopDet;

  state_e        state_q;
  logic [2:0]    bitCnt_q;
  logic [6:0]    rxShift_q;
  logic [7:0]    shiftOut_q;
  logic [PW-1:0] ptr_q;
  logic          rw_q, ackOn_q;
  logic          sdaPadoen_q, wrStb_q, busy_q;
  logic [PW-1:0] wrAddr_q;
  logic [7:0]    wrData_q;
  logic [7:0]    regs_q [NUM_REGS];

  logic [7:0]    rxByte;
  logic [PW-1:0] ptrInc;

  // Two-flop synchronizers feed the glitch filters; prev_q holds the last
  // filtered level so edges on the filtered lines can be seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
      filt_q <= 2'b11;
      prev_q <= 2'b11;
      for (int i = 0; i < 2; i++) filtCnt_q[i] <= '0;
    end else begin
      meta_q <= {sda_pad_i, scl_pad_i};
      sync_q <= meta_q;
      filt_q <= filt_d;
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++) filtCnt_q[i] <= filtCnt_d[i];
    end
  end

  // A filtered line only follows its synchronized input once the input has
  // disagreed with it for FILT_CYCLES consecutive cycles; any agreement
  // restarts the count, so short glitches never get through.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      filtCnt_d[i] = '0;
      if (sync_q[i] != filt_q[i]) begin
        if (filtCnt_q[i] == FILT_MAX) filt_d[i] = sync_q[i];
        else                          filtCnt_d[i] = filtCnt_q[i] + 1'b1;
      end
    end
  end

  assign sclF     = filt_q[0];
  assign sdaF     = filt_q[1];
  assign sclRise  = sclF & ~prev_q[0];
  assign sclFall  = ~sclF & prev_q[0];
  // SCL must be high on both sides of the SDA edge to count as START/STOP.
  assign startDet = sclF & prev_q[0] & prev_q[1] & ~sdaF;
  assign stopDet  = sclF & prev_q[0] & ~prev_q[1] & sdaF;

  assign rxByte = {rxShift_q, sdaF};
  assign ptrInc = ptr_q + 1'b1;

  // Protocol engine. Bits are sampled on filtered SCL rising edges and SDA
  // is only changed on the cycle after a filtered SCL falling edge, except
  // for STOP and reset which always release the line. ACK states use ackOn_q
  // to tell the fall that starts driving ACK from the fall that ends it.
  // The pointer advances past every byte sent on a read, so a later read
  // continues after the last byte the controller received.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      rxShift_q   <= '0;
      shiftOut_q  <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      ackOn_q     <= 1'b0;
      sdaPadoen_q <= 1'b1;
      wrStb_q     <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      wrStb_q <= 1'b0;
      if (stopDet) begin
        state_q     <= IDLE;
        sdaPadoen_q <= 1'b1;
        busy_q      <= 1'b0;
        bitCnt_q    <= '0;
        ackOn_q     <= 1'b0;
      end else if (startDet) begin
        state_q  <= DEV_ADDR;
        busy_q   <= 1'b1;
        bitCnt_q <= '0;
        ackOn_q  <= 1'b0;
      end else begin
        case (state_q)
          DEV_ADDR: if (sclRise) begin
            rxShift_q <= rxByte[6:0];
            bitCnt_q  <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              rw_q    <= rxByte[0];
              state_q <= (rxByte[7:1] == SLAVE_ADDR) ? DEV_ACK : IGNORE;
            end
          end
          PTR: if (sclRise) begin
            rxShift_q <= rxByte[6:0];
            bitCnt_q  <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              ptr_q   <= rxByte[PW-1:0];
              state_q <= PTR_ACK;
            end
          end
          WDATA: if (sclRise) begin
            rxShift_q <= rxByte[6:0];
            bitCnt_q  <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              regs_q[ptr_q] <= rxByte;
              wrStb_q       <= 1'b1;
              wrAddr_q      <= ptr_q;
              wrData_q      <= rxByte;
              ptr_q         <= ptrInc;
              state_q       <= WDATA_ACK;
            end
          end
          DEV_ACK, PTR_ACK, WDATA_ACK: if (sclFall) begin
            if (!ackOn_q) begin
              sdaPadoen_q <= 1'b0;
              ackOn_q     <= 1'b1;
            end else begin
              ackOn_q <= 1'b0;
              if (state_q == DEV_ACK && rw_q) begin
                shiftOut_q  <= regs_q[ptr_q];
                sdaPadoen_q <= regs_q[ptr_q][7];
                state_q     <= RDATA;
              end else begin
                sdaPadoen_q <= 1'b1;
                state_q     <= (state_q == DEV_ACK) ? PTR : WDATA;
              end
            end
          end
          RDATA: begin
            if (sclFall) sdaPadoen_q <= shiftOut_q[~bitCnt_q];
            if (sclRise) begin
              bitCnt_q <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) state_q <= RDATA_ACK;
            end
          end
          RDATA_ACK: begin
            if (sclFall) sdaPadoen_q <= 1'b1;
            if (sclRise) begin
              ptr_q <= ptrInc;
              if (!sdaF) begin
                shiftOut_q <= regs_q[ptrInc];
                state_q    <= RDATA;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          IDLE, IGNORE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sda_padoen_o = sdaPadoen_q;
  assign wr_stb_o     = wrStb_q;
  assign wr_addr_o    = wrAddr_q;
  assign wr_data_o    = wrData_q;
  assign busy_o       = busy_q;
  assign loc_rdata_o  = regs_q[loc_addr_i];

endmodule

// File: tb/tb_i2c_target_regfile.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regfile
// Self-checking bench for i2c_target_regfile. A bit-banged I2C controller
// drives an open-drain SDA line (pulled up, ANDed with the target's enable)
// and a reference model keeps the register contents, the pointer and the
// expected write-strobe log as plain arrays and queues.
// ---------------------------------------------------------------------------
module tb_i2c_target_regfile;

  localparam int NUM_REGS = 16;
  localparam int PW       = 4;
  localparam int Q        = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclDrv = 1'b1;
  logic          sdaCtrl = 1'b1;
  logic [PW-1:0] locAddr = '0;
  logic          sdaPadoen, wrStb, busy;
  logic [PW-1:0] wrAddr;
  logic [7:0]    wrData, locRdata;
  logic          sdaLine;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [NUM_REGS];
  int          mPtr;
  logic [11:0] wrLog[$];
  logic [11:0] expLog[$];
  logic [7:0]  locPrev = 8'h00, locBeforeStb = 8'h00, locAtStb = 8'h00;
  int          highChanges = 0;
  int          padLowCnt = 0;
  logic        padPrev = 1'b1;

  assign sdaLine = sdaCtrl & sdaPadoen;

  i2c_target_regfile #(
    .SLAVE_ADDR (7'h50),
    .NUM_REGS   (NUM_REGS),
    .FILT_CYCLES(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scl_pad_i   (sclDrv),
    .sda_pad_i   (sdaLine),
    .sda_padoen_o(sdaPadoen),
    .wr_stb_o    (wrStb),
    .wr_addr_o   (wrAddr),
    .wr_data_o   (wrData),
    .loc_addr_i  (locAddr),
    .loc_rdata_o (locRdata),
    .busy_o      (busy)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Bus observer: logs write strobes, remembers the local read value just
  // before and at a strobe, and counts SDA enable changes while SCL is high.
  always @(negedge clk) begin
    if (wrStb) begin
      wrLog.push_back({wrAddr, wrData});
      locAtStb     = locRdata;
      locBeforeStb = locPrev;
    end
    locPrev = locRdata;
    if (!rst && sclDrv && (sdaPadoen !== padPrev)) highChanges++;
    if (sdaPadoen === 1'b0) padLowCnt++;
    padPrev = sdaPadoen;
  end

  task automatic waitQ();
    repeat (Q) @(negedge clk);
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 8'h00;
    mPtr = 0;
  endtask

  // START from idle or repeated START from SCL low.
  task automatic busStart();
    sdaCtrl = 1'b1; waitQ();
    sclDrv  = 1'b1; waitQ();
    sdaCtrl = 1'b0; waitQ();
    sclDrv  = 1'b0; waitQ();
  endtask

  task automatic busStop();
    sdaCtrl = 1'b0; waitQ();
    sclDrv  = 1'b1; waitQ();
    sdaCtrl = 1'b1; waitQ();
  endtask

  // One SCL clock; optional 2-cycle low glitch in the high phase.
  task automatic i2cBit(input logic b, input bit glitch, output logic s);
    sdaCtrl = b; waitQ();
    sclDrv  = 1'b1; waitQ();
    s = sdaLine;
    if (glitch) begin
      repeat (3) @(negedge clk);
      sclDrv = 1'b0;
      repeat (2) @(negedge clk);
      sclDrv = 1'b1;
      repeat (Q - 5) @(negedge clk);
    end else begin
      waitQ();
    end
    sclDrv = 1'b0; waitQ();
  endtask

  task automatic sendByte(input logic [7:0] b, input int glitchBit, output logic ackBit);
    logic s;
    for (int i = 7; i >= 0; i--) i2cBit(b[i], (i == glitchBit), s);
    i2cBit(1'b1, 1'b0, ackBit);
  endtask

  task automatic recvByte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2cBit(1'b1, 1'b0, s);
      b[i] = s;
    end
    i2cBit(nack, 1'b0, s);
  endtask

  task automatic checkLog(input string name);
    checks++;
    if (wrLog.size() !== expLog.size()) begin
      failures++;
      $display("[TB] FAIL %s_count: got %0d expected %0d", name, wrLog.size(), expLog.size());
    end else begin
      for (int i = 0; i < expLog.size(); i++) begin
        checks++;
        if (wrLog[i] !== expLog[i]) begin
          failures++;
          $display("[TB] FAIL %s_entry%0d: got %h expected %h", name, i, wrLog[i], expLog[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checks++; if (sdaPadoen !== 1'b1) begin failures++; $display("[TB] FAIL reset_padoen: got %b expected 1", sdaPadoen); end
    checks++; if (wrStb !== 1'b0) begin failures++; $display("[TB] FAIL reset_wrstb: got %b expected 0", wrStb); end
    checks++; if (wrAddr !== 4'h0) begin failures++; $display("[TB] FAIL reset_wraddr: got %h expected 0", wrAddr); end
    checks++; if (wrData !== 8'h00) begin failures++; $display("[TB] FAIL reset_wrdata: got %h expected 00", wrData); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    for (int i = 0; i < NUM_REGS; i++) begin
      locAddr = PW'(i);
      @(negedge clk);
      checks++;
      if (locRdata !== mem[i]) begin failures++; $display("[TB] FAIL reset_reg%0d: got %h expected %h", i, locRdata, mem[i]); end
    end
  endtask

  task automatic test_write();
    logic ack;
    logic [7:0] oldVal;
    logic [7:0] data [2];
    data[0] = 8'h5A; data[1] = 8'hC3;
    wrLog.delete(); expLog.delete();
    locAddr = 4'd4;
    busStart();
    sendByte(8'hA0, -1, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL write_devaddr_ack: got %b expected 0", ack); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL write_busy: got %b expected 1", busy); end
    sendByte(8'h03, -1, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL write_ptr_ack: got %b expected 0", ack); end
    mPtr = 3;
    oldVal = mem[4];
    for (int k = 0; k < 2; k++) begin
      sendByte(data[k], -1, ack);
      checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL write_data%0d_ack: got %b expected 0", k, ack); end
      expLog.push_back({PW'(mPtr), data[k]});
      mem[mPtr] = data[k];
      mPtr = (mPtr + 1) % NUM_REGS;
    end
    busStop();
    checkLog("write_strobe");
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL write_busy_after_stop: got %b expected 0", busy); end
    checks++; if (locRdata !== mem[4]) begin failures++; $display("[TB] FAIL write_loc4: got %h expected %h", locRdata, mem[4]); end
    checks++; if (locBeforeStb !== oldVal) begin failures++; $display("[TB] FAIL write_loc_old: got %h expected %h", locBeforeStb, oldVal); end
    checks++; if (locAtStb !== mem[4]) begin failures++; $display("[TB] FAIL write_loc_new: got %h expected %h", locAtStb, mem[4]); end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] b;
    busStart();
    sendByte(8'hA0, -1, ack);
    sendByte(8'h03, -1, ack);
    mPtr = 3;
    busStart();
    sendByte(8'hA1, -1, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL read_devaddr_ack: got %b expected 0", ack); end
    for (int k = 0; k < 2; k++) begin
      recvByte(k == 1, b);
      checks++; if (b !== mem[mPtr]) begin failures++; $display("[TB] FAIL read_byte%0d: got %h expected %h", k, b, mem[mPtr]); end
      mPtr = (mPtr + 1) % NUM_REGS;
    end
    busStop();
    busStart();
    sendByte(8'hA1, -1, ack);
    recvByte(1'b1, b);
    checks++; if (b !== mem[mPtr]) begin failures++; $display("[TB] FAIL read_kept_ptr: got %h expected %h", b, mem[mPtr]); end
    mPtr = (mPtr + 1) % NUM_REGS;
    busStop();
  endtask

  task automatic test_mismatch();
    logic ack;
    wrLog.delete();
    padLowCnt = 0;
    busStart();
    sendByte(8'hA2, -1, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL mismatch_addr_nack: got %b expected 1", ack); end
    sendByte(8'h11, -1, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL mismatch_data_nack: got %b expected 1", ack); end
    checks++; if (padLowCnt !== 0) begin failures++; $display("[TB] FAIL mismatch_sda_driven: got %0d low cycles expected 0", padLowCnt); end
    checks++; if (wrLog.size() !== 0) begin failures++; $display("[TB] FAIL mismatch_no_strobe: got %0d expected 0", wrLog.size()); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mismatch_busy: got %b expected 1", busy); end
    busStop();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mismatch_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_wrap();
    logic ack;
    logic [7:0] data [2];
    data[0] = 8'hAA; data[1] = 8'hBB;
    wrLog.delete(); expLog.delete();
    busStart();
    sendByte(8'hA0, -1, ack);
    sendByte(8'h0F, -1, ack);
    mPtr = 8'h0F % NUM_REGS;
    for (int k = 0; k < 2; k++) begin
      sendByte(data[k], -1, ack);
      checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL wrap_data%0d_ack: got %b expected 0", k, ack); end
      expLog.push_back({PW'(mPtr), data[k]});
      mem[mPtr] = data[k];
      mPtr = (mPtr + 1) % NUM_REGS;
    end
    busStop();
    checkLog("wrap_strobe");
    locAddr = 4'd15; @(negedge clk);
    checks++; if (locRdata !== mem[15]) begin failures++; $display("[TB] FAIL wrap_reg15: got %h expected %h", locRdata, mem[15]); end
    locAddr = 4'd0; @(negedge clk);
    checks++; if (locRdata !== mem[0]) begin failures++; $display("[TB] FAIL wrap_reg0: got %h expected %h", locRdata, mem[0]); end
  endtask

  task automatic test_random();
    logic ack;
    logic [7:0] pb, d, b;
    int n;
    for (int it = 0; it < 4; it++) begin
      pb = 8'($urandom_range(0, 255));
      n  = $urandom_range(1, 3);
      wrLog.delete(); expLog.delete();
      busStart();
      sendByte(8'hA0, -1, ack);
      sendByte(pb, -1, ack);
      mPtr = pb % NUM_REGS;
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        sendByte(d, -1, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL rand%0d_ack%0d: got %b expected 0", it, k, ack); end
        expLog.push_back({PW'(mPtr), d});
        mem[mPtr] = d;
        mPtr = (mPtr + 1) % NUM_REGS;
      end
      busStop();
      checkLog("rand_strobe");
      busStart();
      sendByte(8'hA0, -1, ack);
      sendByte(pb, -1, ack);
      busStart();
      sendByte(8'hA1, -1, ack);
      mPtr = pb % NUM_REGS;
      for (int k = 0; k < n; k++) begin
        recvByte(k == n - 1, b);
        checks++; if (b !== mem[mPtr]) begin failures++; $display("[TB] FAIL rand%0d_read%0d: got %h expected %h", it, k, b, mem[mPtr]); end
        mPtr = (mPtr + 1) % NUM_REGS;
      end
      busStop();
      locAddr = PW'($urandom_range(0, NUM_REGS - 1));
      @(negedge clk);
      checks++; if (locRdata !== mem[locAddr]) begin failures++; $display("[TB] FAIL rand%0d_loc: got %h expected %h", it, locRdata, mem[locAddr]); end
    end
  endtask

  task automatic test_glitch_reset();
    logic ack;
    logic [7:0] b;
    wrLog.delete(); expLog.delete();
    busStart();
    sendByte(8'hA0, -1, ack);
    sendByte(8'h07, 3, ack);
    mPtr = 7;
    sendByte(8'h3C, 5, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL glitch_ack: got %b expected 0", ack); end
    expLog.push_back({PW'(mPtr), 8'h3C}); mem[mPtr] = 8'h3C; mPtr = (mPtr + 1) % NUM_REGS;
    sendByte(8'h81, 0, ack);
    expLog.push_back({PW'(mPtr), 8'h81}); mem[mPtr] = 8'h81; mPtr = (mPtr + 1) % NUM_REGS;
    busStop();
    checkLog("glitch_strobe");

    busStart();
    sendByte(8'hA0, -1, ack);
    sendByte(8'h07, -1, ack);
    busStart();
    sendByte(8'hA1, -1, ack);
    checks++; if (sdaPadoen !== mem[7][7]) begin failures++; $display("[TB] FAIL rdata_first_bit: got %b expected %b", sdaPadoen, mem[7][7]); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sdaPadoen !== 1'b1) begin failures++; $display("[TB] FAIL reset_release: got %b expected 1", sdaPadoen); end
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid_busy: got %b expected 0", busy); end
    locAddr = 4'd7; @(negedge clk);
    checks++; if (locRdata !== mem[7]) begin failures++; $display("[TB] FAIL reset_mid_reg7: got %h expected %h", locRdata, mem[7]); end
    sendByte(8'hA0, -1, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ignored: got %b expected 1", ack); end
    busStart();
    sendByte(8'hA1, -1, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_ack: got %b expected 0", ack); end
    recvByte(1'b1, b);
    checks++; if (b !== mem[mPtr]) begin failures++; $display("[TB] FAIL post_reset_read: got %h expected %h", b, mem[mPtr]); end
    busStop();
  endtask

  // Test sequence.
  initial begin
    $display("[TB] start");
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_wrap();
    test_random();
    test_glitch_reset();
    checks++;
    if (highChanges !== 0) begin
      failures++;
      $display("[TB] FAIL padoen_change_scl_high: got %0d expected 0", highChanges);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
